// File: rtl/bus_capture_if.sv
// Bus-side bundle for bus_capture: keyed capture bus inputs plus the FIFO drain handshake.
// The master drives the bus and consumes the FIFO. The slave is the bus_capture endpoint.
interface bus_capture_if #(
    parameter int DATA_BUS_SIZE = 16,
    parameter int KEY_SIZE      = 8,
    parameter int DEPTH         = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_BUS_SIZE-1:0] data_in;
    logic [KEY_SIZE-1:0]      key;
    logic                     strobe;
    logic [DATA_BUS_SIZE-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CNT_W-1:0]         count;
    logic                     full;
    logic                     overflow;
    logic                     clr_ovf;

    modport master (
        output data_in, key, strobe, out_ready, clr_ovf,
        input  out_data, out_valid, count, full, overflow
    );

    modport slave (
        input  data_in, key, strobe, out_ready, clr_ovf,
        output out_data, out_valid, count, full, overflow
    );
endinterface

// File: rtl/bus_capture.sv
// Keyed bus capture endpoint: strobed words whose key matches CAPTURE_CODE are queued in a small FIFO.
// Define BUS_CAPTURE_OVERFLOW_EN to enable the sticky overflow flag and its clr_ovf clear.
module bus_capture #(
    parameter int                  DATA_BUS_SIZE = 16,
    parameter int                  KEY_SIZE      = 8,
    parameter logic [KEY_SIZE-1:0] CAPTURE_CODE  = '0,
    parameter int                  DEPTH         = 4
) (
    input logic          clk,
    input logic          rst_n,
    bus_capture_if.slave bus
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_BUS_SIZE-1:0] mem_q [DEPTH];
    logic [DATA_BUS_SIZE-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     hit, full, pop, push;

    always_comb begin
        hit  = bus.strobe && (bus.key == CAPTURE_CODE);
        full = (count_q == DEPTH_C);
        pop  = (count_q != '0) && bus.out_ready;
        push = hit && (!full || pop);
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = bus.data_in;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; out_valid gates whatever it holds.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef BUS_CAPTURE_OVERFLOW_EN
    logic drop;
    logic ovf_q, ovf_d;

    // A drop in the same cycle as clr_ovf keeps the flag set.
    always_comb begin
        drop  = hit && full && !pop;
        ovf_d = ovf_q;
        if (bus.clr_ovf) ovf_d = 1'b0;
        if (drop)        ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.out_valid = (count_q != '0);
    assign bus.count     = count_q;
    assign bus.full      = full;
endmodule

// File: tb/tb_bus_capture.sv
// Directed bench for bus_capture (CAPTURE_CODE=8'h3A, DEPTH=4).
// Overflow expectations follow whether BUS_CAPTURE_OVERFLOW_EN is defined.
module tb_bus_capture;
    localparam int DW = 16;
    localparam int KW = 8;
    localparam int DP = 4;
`ifdef BUS_CAPTURE_OVERFLOW_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    bus_capture_if #(.DATA_BUS_SIZE(DW), .KEY_SIZE(KW), .DEPTH(DP)) bus ();

    bus_capture #(
        .DATA_BUS_SIZE(DW),
        .KEY_SIZE     (KW),
        .CAPTURE_CODE (8'h3A),
        .DEPTH        (DP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic stb, input logic [KW-1:0] k, input logic [DW-1:0] d,
                         input logic rdy, input logic clr);
        bus.strobe    = stb;
        bus.key       = k;
        bus.data_in   = d;
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 8'h00, 16'h0000, rdy, 1'b0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        idle(1'b0);
        #12;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // single capture then pop
        drive(1'b1, 8'h3A, 16'hBEEF, 1'b0, 1'b0);
        cyc();
        idle(1'b0);
        check("cap_valid", 32'(bus.out_valid), 32'd1);
        check("cap_data", 32'(bus.out_data), 32'hBEEF);
        check("cap_count", 32'(bus.count), 32'd1);
        cyc();
        check("cap_hold", 32'(bus.out_data), 32'hBEEF);
        idle(1'b1);
        cyc();
        idle(1'b0);
        check("pop_valid", 32'(bus.out_valid), 32'd0);
        check("pop_count", 32'(bus.count), 32'd0);

        // key filter
        drive(1'b1, 8'h3B, 16'h1234, 1'b0, 1'b0);
        cyc();
        check("badkey_count", 32'(bus.count), 32'd0);
        check("badkey_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b0, 8'h3A, 16'h5678, 1'b0, 1'b0);
        cyc();
        check("nostb_count", 32'(bus.count), 32'd0);
        check("nostb_valid", 32'(bus.out_valid), 32'd0);

        // fill and overflow
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 8'h3A, DW'(i), 1'b0, 1'b0);
            cyc();
            if (i == 4) check("fill4_ovf", 32'(bus.overflow), 32'd0);
        end
        idle(1'b0);
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.count), 32'd4);
        check("fill_ovf", 32'(bus.overflow), 32'(EXP_OVF));
        idle(1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 32'(bus.out_data), 32'(i));
            cyc();
        end
        idle(1'b0);
        check("drain_valid", 32'(bus.out_valid), 32'd0);
        check("drain_full", 32'(bus.full), 32'd0);
        drive(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
        cyc();
        idle(1'b0);
        check("clr_ovf", 32'(bus.overflow), 32'd0);

        // drop coinciding with clr_ovf: set wins
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h3A, DW'(16'h10 + i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b1, 8'h3A, 16'h0077, 1'b0, 1'b1);
        cyc();
        check("setwins_ovf", 32'(bus.overflow), 32'(EXP_OVF));
        check("setwins_count", 32'(bus.count), 32'd4);
        drive(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
        cyc();
        check("clr2_ovf", 32'(bus.overflow), 32'd0);

        // full with simultaneous push and pop
        drive(1'b1, 8'h3A, 16'h00AA, 1'b1, 1'b0);
        check("fpp_head", 32'(bus.out_data), 32'h0010);
        cyc();
        idle(1'b1);
        check("fpp_count", 32'(bus.count), 32'd4);
        check("fpp_ovf", 32'(bus.overflow), 32'd0);
        check("fpp_full", 32'(bus.full), 32'd1);
        check("fpp_d0", 32'(bus.out_data), 32'h0011);
        cyc();
        check("fpp_d1", 32'(bus.out_data), 32'h0012);
        cyc();
        check("fpp_d2", 32'(bus.out_data), 32'h0013);
        cyc();
        check("fpp_d3", 32'(bus.out_data), 32'h00AA);
        cyc();
        idle(1'b0);
        check("fpp_empty", 32'(bus.out_valid), 32'd0);

        // pointer wrap with alternating push/pop
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'h3A, DW'(16'hA000 + i), 1'b0, 1'b0);
            cyc();
            idle(1'b1);
            check("wrap_count1", 32'(bus.count), 32'd1);
            check("wrap_data", 32'(bus.out_data), 32'(16'hA000 + i));
            cyc();
            idle(1'b0);
            check("wrap_count0", 32'(bus.count), 32'd0);
        end

        // reset mid-operation, asserted between edges
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h3A, DW'(16'hC000 + i), 1'b0, 1'b0);
            cyc();
        end
        idle(1'b0);
        check("pre_rst_count", 32'(bus.count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        drive(1'b1, 8'h3A, 16'hCAFE, 1'b0, 1'b0);
        cyc();
        idle(1'b0);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_data", 32'(bus.out_data), 32'hCAFE);
        check("post_rst_count", 32'(bus.count), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
